mips_mc_control: RTL

Multicycle control unit for the MIPS datapath. Sequences one instruction over 3–5 cycles through a single shared memory port, using one ALU and the IR/A/B/ALUOut registers. It decodes the opcode held in IR and drives every mux select, write-enable and ALU-op line. It stalls on a memory ready handshake.

---
 rtl/mips_mc_pkg.sv | 72 +++++++
 rtl/mips_mc_control_outdec.sv | 68 ++++++
 rtl/mips_mc_control.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// State encoding, opcode constants, the datapath-select encodings and the
// control-word struct handed from the output decoder to the top.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
  } ctrl_t;

  // States that own the memory port and therefore wait on mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_mc_control_outdec.sv
// Combinational state -> control-word decode for the multicycle MIPS
// control unit. Pure Moore decode apart from pc_en/ir_write, which follow
// mem_ready in FETCH and zero in BRANCH.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_e state_i,
  input  logic   zero_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Decode the datapath control word for the current state.
  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave a latch.
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      MEMADR, ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PC_ALUOUT;
        ctrl_o.pc_en     = zero_i;
      end
      JUMP: begin
        ctrl_o.pc_src = PC_JUMP;
        ctrl_o.pc_en  = 1'b1;
      end
      ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/execute states over a
// single shared memory port, stalling on mem_ready with an optional
// wait timeout (WAIT_TIMEOUT > 0).
// Optional feature macro: MC_PERF_EN adds cycle_cnt/instr_cnt counters.
module mips_mc_control
  import mips_mc_pkg::*;
#(
`ifdef MC_PERF_EN
  parameter int PERF_W       = 32,
`endif
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [5:0]        opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ir_write,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic [1:0]        pc_src,
  output logic              illegal_op,
  output logic              mem_timeout,
`ifdef MC_PERF_EN
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt,
`endif
  output logic [3:0]        state_o
);

  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             stall;
  logic             timeout;
  logic             illegal;
  ctrl_t            dec_ctrl;
  ctrl_t            ctrl;

  // A stall is a memory-owning state whose access has not completed yet;
  // the timeout fires on the wait cycle that brings the count to WAIT_TIMEOUT.
  assign stall   = is_wait_state(state_q) && !mem_ready;
  assign timeout = (WAIT_TIMEOUT > 0) && stall &&
                   ((int'(wait_cnt_q) + 1) >= WAIT_TIMEOUT);
  assign illegal = (state_q == DECODE) && !op_is_legal(opcode);

  // Wait counter: counts consecutive stall cycles, saturating, and clears
  // whenever the state moves on (including the abort to FETCH).
  always_comb begin
    wait_cnt_d = '0;
    if (stall && !timeout) begin
      if (int'(wait_cnt_q) < WAIT_TIMEOUT) wait_cnt_d = wait_cnt_q + CNT_W'(1);
      else                                 wait_cnt_d = wait_cnt_q;
    end
  end

  // State and wait-counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
    if (nrst) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: opcode dispatch in DECODE, handshake holds, timeout abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:         state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (timeout) state_d = FETCH;
  end

  mips_mc_outdec u_outdec (
    .state_i     (state_q),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec_ctrl)
  );

  // Output logic: decoded control word, forced to all-zero while in reset.
  always_comb begin
    ctrl        = dec_ctrl;
    illegal_op  = illegal;
    mem_timeout = timeout;
    if (nrst) begin
      ctrl        = '0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ir_write   = ctrl.ir_write;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state_o    = state_q;

`ifdef MC_PERF_EN
  logic [PERF_W-1:0] cycle_cnt_q;
  logic [PERF_W-1:0] instr_cnt_q;

  // Performance counters: every running cycle, and every instruction that
  // retires back into FETCH (aborted and illegal instructions excluded).
  always_ff @(posedge clk) begin
    if (nrst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
      if ((state_d == FETCH) && (state_q != FETCH) && !illegal && !timeout)
        instr_cnt_q <= instr_cnt_q + PERF_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
